// File: rtl/uart_rx_cmd.sv
// 8N1 UART receiver for host keyboard commands: 2-flop synchroniser, mid-bit
// 2-of-3 majority sampling, one-cycle strobes for good bytes and framing errors.
module uart_rx_cmd #(
    parameter int CLK_HZ = 25000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dataRX,
    output logic       WR_RX,
    output logic       frame_err,
    output logic       busy
);
    localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
    localparam logic [CW-1:0] CNT_DEC  = CW'(HALF + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [1:0]    smp_q, smp_d;
    logic          armed_q, armed_d;
    logic          rx_meta_q, rx_meta_d;
    logic          rx_s_q, rx_s_d;
    logic [1:0]    sync_vld_q, sync_vld_d;
    logic [7:0]    data_q, data_d;
    logic          wr_q, wr_d;
    logic          ferr_q, ferr_d;
    logic          busy_q, busy_d;
    logic          bit_s;

    // Next-state logic for the synchroniser, sampler, FSM and output strobes.
    always_comb begin
        rx_meta_d  = rx;
        rx_s_d     = rx_meta_q;
        // The synchroniser resets high, so its first two outputs after reset are
        // not the line; sync_vld keeps them from arming the start detector.
        sync_vld_d = {sync_vld_q[0], 1'b1};
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        armed_d    = 1'b0;
        data_d     = data_q;
        wr_d       = 1'b0;
        ferr_d     = 1'b0;
        bit_s      = maj3(smp_q[1], smp_q[0], rx_s_q);

        if (cnt_q == CNT_S0) begin
            smp_d = {rx_s_q, smp_q[0]};
        end else if (cnt_q == CNT_S1) begin
            smp_d = {smp_q[1], rx_s_q};
        end else begin
            smp_d = smp_q;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (armed_q && !rx_s_q) begin
                    state_d = START;
                end else begin
                    armed_d = armed_q | (rx_s_q & sync_vld_q[1]);
                end
            end
            START: begin
                if ((cnt_q == CNT_DEC) && bit_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (cnt_q == CNT_DEC) begin
                    shreg_d = {bit_s, shreg_q[7:1]};
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    shreg_d = shreg_q;
                end
            end
            STOP: begin
                // Decide at mid-stop and leave early to absorb a fast sender.
                if (cnt_q == CNT_DEC) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (bit_s) begin
                        data_d = shreg_q;
                        wr_d   = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; asynchronous reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            sync_vld_q <= 2'b00;
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            shreg_q    <= 8'h00;
            smp_q      <= 2'b00;
            armed_q    <= 1'b0;
            data_q     <= 8'h00;
            wr_q       <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            sync_vld_q <= sync_vld_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            smp_q      <= smp_d;
            armed_q    <= armed_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
        end
    end

    assign dataRX    = data_q;
    assign WR_RX     = wr_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_uart_rx_cmd.sv
// Self-checking bench for uart_rx_cmd: directed scenarios plus random bytes,
// compared against a queue of the bytes the line driver actually sent.
module tb_uart_rx_cmd;
    localparam int CPB  = 217;
    localparam int HALF = 108;
    localparam int LAT  = 2 + 9 * CPB + HALF + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] dataRX;
    logic       WR_RX;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    uart_rx_cmd dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .dataRX   (dataRX),
        .WR_RX    (WR_RX),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed events, recorded on the falling edge.
    logic [7:0] rx_q[$];
    int         rx_cyc_q[$];
    int         ferr_cnt = 0, overlap_cnt = 0, long_cnt = 0, hold_bad = 0;
    int         busy_fall_cyc = -1, last_wr = -1, min_gap = 1000000;
    logic       wr_prev = 1'b0, busy_prev = 1'b0, rst_prev = 1'b1;
    logic [7:0] data_prev = 8'h00;

    always @(negedge clk) begin
        if (WR_RX === 1'b1) begin
            rx_q.push_back(dataRX);
            rx_cyc_q.push_back(cyc);
            if (last_wr >= 0 && (cyc - last_wr) < min_gap) min_gap = cyc - last_wr;
            last_wr = cyc;
        end
        if (frame_err === 1'b1) ferr_cnt++;
        if (WR_RX === 1'b1 && frame_err === 1'b1) overlap_cnt++;
        if (WR_RX === 1'b1 && wr_prev === 1'b1) long_cnt++;
        if (rst === 1'b0 && rst_prev === 1'b0 && WR_RX !== 1'b1 && dataRX !== data_prev) hold_bad++;
        if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
        wr_prev   = WR_RX;
        busy_prev = busy;
        rst_prev  = rst;
        data_prev = dataRX;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int got, input int lo, input int hi);
        checks++;
        assert (got >= lo && got <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, got, lo, hi);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame with bit period CPB*f; st is the edge-0 cycle index.
    task automatic send_frame(input logic [7:0] b, input real f, input logic stop_v, output int st);
        real        per;
        int         prev, nxt;
        logic [9:0] bits;
        per  = CPB * f;
        prev = 0;
        bits = {stop_v, b, 1'b0};
        st   = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            nxt = int'((i + 1) * per);
            rx  = bits[i];
            repeat (nxt - prev) @(negedge clk);
            prev = nxt;
        end
    endtask

    initial begin
        int         st, base, fb;
        logic [7:0] exp_q[$];
        logic [7:0] b;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_dataRX", dataRX, 8'h00);
        chk("reset_wr", WR_RX, 1'b0);
        chk("reset_ferr", frame_err, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b0;
        idle(20);

        // Single 'A' and its latency
        base = rx_q.size(); fb = ferr_cnt;
        send_frame(8'h41, 1.0, 1'b1, st);
        idle(300);
        chk("t1_count", rx_q.size() - base, 1);
        if (rx_q.size() > base) begin
            chk("t1_data", rx_q[base], 8'h41);
            chk_rng("t1_latency", rx_cyc_q[base] - st, LAT - 1, LAT + 1);
        end
        chk("t1_ferr", ferr_cnt - fb, 0);
        chk("t1_hold", dataRX, 8'h41);

        // Back-to-back ABCD
        base = rx_q.size(); fb = ferr_cnt;
        fork
            begin
                send_frame(8'h41, 1.0, 1'b1, st);
                send_frame(8'h42, 1.0, 1'b1, st);
                send_frame(8'h43, 1.0, 1'b1, st);
                send_frame(8'h44, 1.0, 1'b1, st);
            end
            begin
                repeat (1000) @(negedge clk);
                chk("t2_busy_mid", busy, 1'b1);
            end
        join
        idle(300);
        chk("t2_count", rx_q.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (rx_q.size() > base + i) chk("t2_data", rx_q[base + i], 8'h41 + i);
        end
        chk("t2_ferr", ferr_cnt - fb, 0);

        // 50-cycle glitch on an idle line
        base = rx_q.size(); fb = ferr_cnt;
        st = cyc + 1;
        rx = 1'b0;
        repeat (50) @(negedge clk);
        idle(300);
        chk("t3_no_wr", rx_q.size() - base, 0);
        chk("t3_no_ferr", ferr_cnt - fb, 0);
        chk_rng("t3_busy_fall", busy_fall_cyc - st, 2 + HALF + 1, 2 + HALF + 3);
        chk("t3_busy", busy, 1'b0);

        // Framing error, then recovery
        base = rx_q.size(); fb = ferr_cnt;
        send_frame(8'h55, 1.0, 1'b0, st);
        chk("t4_ferr", ferr_cnt - fb, 1);
        chk("t4_keep", dataRX, 8'h44);
        chk("t4_no_wr", rx_q.size() - base, 0);
        idle(3 * CPB);
        send_frame(8'h43, 1.0, 1'b1, st);
        idle(300);
        chk("t4_count", rx_q.size() - base, 1);
        if (rx_q.size() > base) chk("t4_data", rx_q[base], 8'h43);
        chk("t4_ferr_total", ferr_cnt - fb, 1);

        // Reset mid-byte, line held low across release
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_rst_dataRX", dataRX, 8'h00);
        chk("t5_rst_wr", WR_RX, 1'b0);
        chk("t5_rst_ferr", frame_err, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        base = rx_q.size(); fb = ferr_cnt;
        rst = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        idle(2 * CPB);
        chk("t5_no_partial", rx_q.size() - base, 0);
        send_frame(8'h44, 1.0, 1'b1, st);
        idle(300);
        chk("t5_count", rx_q.size() - base, 1);
        if (rx_q.size() > base) chk("t5_data", rx_q[base], 8'h44);
        chk("t5_ferr", ferr_cnt - fb, 0);

        // Drift +4% / -4%
        base = rx_q.size(); fb = ferr_cnt;
        send_frame(8'h7E, 1.04, 1'b1, st);
        idle(2 * CPB);
        send_frame(8'h7E, 0.96, 1'b1, st);
        idle(2 * CPB);
        chk("t6_count", rx_q.size() - base, 2);
        for (int i = 0; i < 2; i++) begin
            if (rx_q.size() > base + i) chk("t6_data", rx_q[base + i], 8'h7E);
        end
        chk("t6_ferr", ferr_cnt - fb, 0);

        // Random bytes with random idle gaps (including zero)
        base = rx_q.size(); fb = ferr_cnt;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1.0, 1'b1, st);
            idle($urandom_range(0, 400));
        end
        idle(300);
        chk("rnd_count", rx_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (rx_q.size() > base + i) chk("rnd_data", rx_q[base + i], exp_q[i]);
        end
        chk("rnd_ferr", ferr_cnt - fb, 0);

        // Global strobe rules
        chk("overlap", overlap_cnt, 0);
        chk("wr_one_cycle", long_cnt, 0);
        chk("data_hold", hold_bad, 0);
        chk_rng("wr_min_gap", min_gap, 9 * CPB, 1000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
